i2s_frame_clkgen: RTL and testbench
===================================

# i2s_frame_clkgen

Parametrised audio clock and frame generator for the I2S core. It derives the bit clock (BCLK) and word-select/frame clock (LRCLK) from the 12.288 MHz master clock. Divider, slot width, channel count and framing mode are configurable, and it exposes bit/slot position and edge strobes so serializers/deserializers run single-clock on `clock_in`. Defaults reproduce 3.072 MHz BCLK / 48 kHz LRCLK stereo, and the block adds TDM, I2S/left-justified framing, runtime rate change and clean start/stop.

## Interface
- `SLOT_WIDTH`, 32: BCLK periods per channel slot; power of two, ≥ 8.
- `CHANNELS`, 2: slots per frame; even, ≥ 2 (2 = stereo, 4/8 = TDM).
- `DIV_W`, 8: width of the BCLK half-period divider.

- `clock_in`  in  1  master clock (12.288 MHz); sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; start/stop only at frame boundaries.
- `bclk_half`  in  DIV_W  BCLK half-period in `clock_in` cycles; 0 is treated as 1.
- `i2s_mode`  in  1  1 = I2S (LRCLK leads slot by one BCLK), 0 = left-justified.
- `bclk`  out  1  bit clock, registered.
- `lrclk`  out  1  frame clock, registered. Low = slots 0..CHANNELS/2-1, high = remaining slots.
- `bclk_rise`  out  1  one-cycle strobe, the cycle `bclk` goes 0→1.
- `bclk_fall`  out  1  one-cycle strobe, the cycle `bclk` goes 1→0.
- `frame_start`  out  1  one-cycle strobe, first cycle of each frame.
- `slot_idx`  out  $clog2(CHANNELS)  current slot.
- `bit_idx`  out  $clog2(SLOT_WIDTH)  current bit, counts SLOT_WIDTH-1 down to 0 (MSB first).
- `active`  out  1  generator running.

## Operation
- Reset values: `bclk`=0, `lrclk`=0, all strobes 0, `slot_idx`=0, `bit_idx`=SLOT_WIDTH-1, `active`=0. Divider count and shadow config are cleared.
- States: IDLE, RUN.
- **IDLE**
  - `bclk` and `lrclk` are held low.
  - When `enable`=1, the next edge moves to RUN. On that edge: `active`=1, `frame_start`=1, `bclk_half` and `i2s_mode` are loaded into shadow registers, and the divider count is cleared.
- **RUN, divider**
  - The divider counts 0..H-1, where H = max(shadow `bclk_half`, 1).
  - At count H-1, `bclk` toggles, the count returns to 0, and the matching strobe fires in that same cycle.
- **RUN, position counters** (update only on the `bclk_fall` cycle; data changes on falling edges)
  - `bit_idx` decrements.
  - When `bit_idx` wraps 0→SLOT_WIDTH-1, `slot_idx` increments.
  - When `slot_idx` wraps CHANNELS-1→0, it is a frame boundary.
- **lrclk**
  - Left-justified: `lrclk` = (new `slot_idx` ≥ CHANNELS/2), updated on the same fall.
  - I2S: `lrclk` goes 1 on the fall where `bit_idx` becomes 0 in slot CHANNELS/2-1. It goes 0 on the fall where `bit_idx` becomes 0 in slot CHANNELS-1.
- **Frame boundary fall**
  - `frame_start`=1.
  - Shadow `bclk_half` and `i2s_mode` reload from the inputs; changes applied mid-frame take effect only here.
  - If `enable`=0: go to IDLE, `active`=0, counters return to reset values, `bclk` stays 0.
- **Enable and reset behaviour**
  - `enable` dropping and re-rising before a boundary has no effect.
  - `reset_n` low mid-frame forces reset values immediately (asynchronously), with no partial frame completion.

## Timing
- Start latency: `enable` sampled high → `active`/`frame_start` next cycle. The first `bclk_rise` follows H cycles later.
- BCLK period = 2·H `clock_in` cycles. Frame period = 2·H·SLOT_WIDTH·CHANNELS cycles.
- Defaults with H=2: BCLK 3.072 MHz (4 cycles), frame 256 cycles = 48 kHz.
- `frame_start` after start coincides with `bclk_fall`. At most one strobe per cycle, except that `frame_start` may coincide with `bclk_fall`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, `bclk_half`=2, `i2s_mode`=0, `enable`=1 → `bclk` period 4, `lrclk` period 256 with 128 low/128 high, `frame_start` every 256 cycles, `bit_idx` 31→0 per slot.
- `i2s_mode`=1 → `lrclk` rises one BCLK (4 cycles) before `slot_idx` becomes 1, i.e. at the fall where `bit_idx`=0 in slot 0. It falls one BCLK before the frame wrap.
- Change `bclk_half` 2→3 mid-frame → current frame finishes at period 4. From the next `frame_start`, period is 6 and the frame is 384 cycles. `bclk_half`=0 gives period 2.
- Drop `enable` at slot 0 bit 20 → frame completes, then IDLE: `active`=0, `bclk`=`lrclk`=0, no further strobes. A pulse low/high within a frame → no interruption.
- Assert `reset_n`=0 mid-frame → all outputs take reset values without waiting for a clock. After release with `enable`=1, a fresh frame starts.
- `CHANNELS`=8, `SLOT_WIDTH`=32, H=1 → `slot_idx` cycles 0..7, `lrclk` high for slots 4..7, frame = 512 cycles.

Source files
------------

// File: rtl/i2s_frame_clkgen.sv
// i2s_frame_clkgen
//   Derives the I2S bit clock (bclk) and frame clock (lrclk) from clock_in,
//   and publishes slot/bit position plus edge strobes so serializers can run
//   single-clock on clock_in.
//
// Parameters
//   SLOT_WIDTH  bclk periods per channel slot (power of two, >= 8)
//   CHANNELS    slots per frame (even, >= 2)
//   DIV_W       width of the bclk half-period divider
//
// Ports
//   clock_in     master clock, sole clock
//   reset_n      asynchronous active-low reset
//   enable       run request; start/stop honoured only at frame boundaries
//   bclk_half    bclk half-period in clock_in cycles (0 behaves as 1)
//   i2s_mode     1 = I2S framing (lrclk one bclk early), 0 = left-justified
//   bclk, lrclk  registered bit and frame clocks
//   bclk_rise    strobe in the cycle bclk goes 0->1
//   bclk_fall    strobe in the cycle bclk goes 1->0
//   frame_start  strobe in the first cycle of each frame
//   slot_idx     current slot
//   bit_idx      current bit, SLOT_WIDTH-1 down to 0
//   active       generator running
module i2s_frame_clkgen #(
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DIV_W      = 8
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              bclk_half,
  input  logic                          i2s_mode,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          bclk_rise,
  output logic                          bclk_fall,
  output logic                          frame_start,
  output logic [$clog2(CHANNELS)-1:0]   slot_idx,
  output logic [$clog2(SLOT_WIDTH)-1:0] bit_idx,
  output logic                          active
);

  localparam int SLOT_W = $clog2(CHANNELS);
  localparam int BIT_W  = $clog2(SLOT_WIDTH);

  localparam logic [BIT_W-1:0]  BIT_TOP        = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF      = SLOT_W'(CHANNELS / 2);
  localparam logic [SLOT_W-1:0] SLOT_HALF_LAST = SLOT_W'(CHANNELS / 2 - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    half_q, half_d;
  logic                mode_q, mode_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                fs_q, fs_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                active_q, active_d;

  logic [DIV_W-1:0]    half_eff;
  logic                tick;
  logic                fall_evt;
  logic                frame_end;

  // Divider terminal count and the events derived from it
  always_comb begin
    half_eff  = (half_q == '0) ? DIV_W'(1) : half_q;
    tick      = (state_q == S_RUN) && (cnt_q == half_eff - DIV_W'(1));
    fall_evt  = tick && bclk_q;
    frame_end = fall_evt && (bit_q == '0) && (slot_q == SLOT_LAST);
  end

  // State register plus all datapath flops
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      mode_q   <= 1'b0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      fs_q     <= 1'b0;
      slot_q   <= '0;
      bit_q    <= BIT_TOP;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      mode_q   <= mode_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      fs_q     <= fs_d;
      slot_q   <= slot_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN:  if (frame_end && !enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    mode_d   = mode_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    fs_d     = 1'b0;
    slot_d   = slot_q;
    bit_d    = bit_q;
    active_d = active_q;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        bclk_d   = 1'b0;
        lrclk_d  = 1'b0;
        slot_d   = '0;
        bit_d    = BIT_TOP;
        active_d = 1'b0;
        if (enable) begin
          active_d = 1'b1;
          fs_d     = 1'b1;
          half_d   = bclk_half;
          mode_d   = i2s_mode;
        end
      end

      S_RUN: begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        if (tick) begin
          bclk_d = !bclk_q;
          rise_d = !bclk_q;
          fall_d = bclk_q;
        end

        // Position advances on falling edges; bit_idx wraps naturally
        // because SLOT_WIDTH is a power of two.
        if (fall_evt) begin
          bit_d = bit_q - BIT_W'(1);
          if (bit_q == '0)
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

          if (!mode_q) begin
            lrclk_d = (slot_d >= SLOT_HALF);
          end else if (bit_q == BIT_W'(1)) begin
            // I2S: lrclk changes one bclk ahead of the slot it announces
            if (slot_q == SLOT_HALF_LAST)
              lrclk_d = 1'b1;
            else if (slot_q == SLOT_LAST)
              lrclk_d = 1'b0;
          end
        end

        if (frame_end) begin
          fs_d   = 1'b1;
          half_d = bclk_half;
          mode_d = i2s_mode;
          if (!enable) begin
            active_d = 1'b0;
            cnt_d    = '0;
            bclk_d   = 1'b0;
            lrclk_d  = 1'b0;
            slot_d   = '0;
            bit_d    = BIT_TOP;
          end
        end
      end

      default: ;
    endcase
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign active      = active_q;

endmodule

// File: tb/tb_i2s_frame_clkgen.sv
// Bench for i2s_frame_clkgen: a stereo instance checked event-by-event
// against a frame-position reference model, and an 8-slot TDM instance
// checked for slot/lrclk sequence and frame period.
module tb_i2s_frame_clkgen;

  localparam int SW  = 32;
  localparam int CH  = 2;
  localparam int N   = SW * CH;
  localparam int SLW = $clog2(CH);
  localparam int BIW = $clog2(SW);
  localparam int VW  = 6 + SLW + BIW;

  localparam int TSW = 32;
  localparam int TCH = 8;
  localparam int TN  = TSW * TCH;
  localparam int TH  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic           reset_n, enable, i2s_mode;
  logic [7:0]     bclk_half;
  logic           bclk, lrclk, bclk_rise, bclk_fall, frame_start, active;
  logic [SLW-1:0] slot_idx;
  logic [BIW-1:0] bit_idx;

  i2s_frame_clkgen #(.SLOT_WIDTH(SW), .CHANNELS(CH), .DIV_W(8)) u_dut (
    .clock_in(clk), .reset_n(reset_n), .enable(enable), .bclk_half(bclk_half),
    .i2s_mode(i2s_mode), .bclk(bclk), .lrclk(lrclk), .bclk_rise(bclk_rise),
    .bclk_fall(bclk_fall), .frame_start(frame_start), .slot_idx(slot_idx),
    .bit_idx(bit_idx), .active(active)
  );

  // TDM instance
  logic       t_rst_n, t_en, t_mode;
  logic [7:0] t_half;
  logic       t_bclk, t_lrclk, t_rise, t_fall, t_fs, t_active;
  logic [2:0] t_slot;
  logic [4:0] t_bit;

  i2s_frame_clkgen #(.SLOT_WIDTH(TSW), .CHANNELS(TCH), .DIV_W(8)) u_tdm (
    .clock_in(clk), .reset_n(t_rst_n), .enable(t_en), .bclk_half(t_half),
    .i2s_mode(t_mode), .bclk(t_bclk), .lrclk(t_lrclk), .bclk_rise(t_rise),
    .bclk_fall(t_fall), .frame_start(t_fs), .slot_idx(t_slot),
    .bit_idx(t_bit), .active(t_active)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    int            cyc;
    logic [VW-1:0] v;
  } ev_t;

  ev_t sb[$];

  // Output snapshot for a frame position p (number of falls since frame start)
  function automatic logic [VW-1:0] pack(logic bc, logic lr, logic ri, logic fa,
                                         logic fs, int p, logic act);
    logic [SLW-1:0] s;
    logic [BIW-1:0] b;
    s = SLW'(p / SW);
    b = BIW'(SW - 1 - (p % SW));
    return {bc, lr, ri, fa, fs, s, b, act};
  endfunction

  // Left-justified: high for the second half of the frame.
  // I2S: same window shifted one bit earlier.
  function automatic logic lr_of(int p, logic md);
    if (md) return (((p + 1) % N) >= N / 2);
    return (p >= N / 2);
  endfunction

  function automatic int hof(logic [7:0] hv);
    return (hv == 8'd0) ? 1 : int'(hv);
  endfunction

  // Reference model: events are scheduled at multiples of H from frame start
  int   cyc = 0;
  bit   m_run = 1'b0;
  int   t0, h, d, j;
  logic md;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      m_run = 1'b0;
      sb.delete();
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1'b1;
        t0 = cyc;
        h  = hof(bclk_half);
        md = i2s_mode;
        sb.push_back('{cyc, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1)});
      end
    end else begin
      d = cyc - t0;
      if (d % h == 0) begin
        j = d / h;
        if (j % 2 == 1) begin
          sb.push_back('{cyc, pack(1'b1, lr_of((j - 1) / 2, md), 1'b1, 1'b0, 1'b0,
                                   (j - 1) / 2, 1'b1)});
        end else if (j / 2 < N) begin
          sb.push_back('{cyc, pack(1'b0, lr_of(j / 2, md), 1'b0, 1'b1, 1'b0,
                                   j / 2, 1'b1)});
        end else begin
          t0 = cyc;
          h  = hof(bclk_half);
          md = i2s_mode;
          if (!enable) m_run = 1'b0;
          sb.push_back('{cyc, pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, m_run)});
        end
      end
    end
  end

  // Monitor: scoreboard pops on strobes, plus idle/reset level checks and TDM checks
  logic [VW-1:0] act_v;
  ev_t           e;
  int            tp = 0;
  int            tfs_cyc = 0;
  bit            tstarted = 1'b0;
  logic [9:0]    t_act, t_exp;

  always @(negedge clk) begin
    act_v = {bclk, lrclk, bclk_rise, bclk_fall, frame_start, slot_idx, bit_idx, active};

    if (!reset_n) begin
      sb.delete();
      n_cmp++;
      if (act_v !== pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_values cyc=%0d got=%b want=%b", cyc, act_v,
                 pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      end
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missed_event cyc=%0d got=none want=%b@%0d", cyc, e.v, e.cyc);
      end

      if (bclk_rise || bclk_fall || frame_start) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe cyc=%0d got=%b want=none", cyc, act_v);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.v !== act_v) begin
            n_fail++;
            $display("FAIL strobe_event cyc=%0d got=%b want=%b@%0d", cyc, act_v, e.v, e.cyc);
          end
        end
      end

      n_cmp++;
      if (active !== m_run || (!m_run && (bclk || lrclk || slot_idx != '0 ||
                                           bit_idx != BIW'(SW - 1)))) begin
        n_fail++;
        $display("FAIL run_level cyc=%0d got=active%b bclk%b lrclk%b slot%0d bit%0d want=active%b",
                 cyc, active, bclk, lrclk, slot_idx, bit_idx, m_run);
      end
    end

    if (!t_rst_n) begin
      tstarted = 1'b0;
    end else if (t_fs && !t_fall) begin
      tstarted = 1'b1;
      tp = 0;
      tfs_cyc = cyc;
      n_cmp++;
      if (t_slot != 3'd0 || t_bit != 5'd31 || t_lrclk) begin
        n_fail++;
        $display("FAIL tdm_start cyc=%0d got=slot%0d bit%0d lr%b want=slot0 bit31 lr0",
                 cyc, t_slot, t_bit, t_lrclk);
      end
    end else if (t_fall && tstarted) begin
      tp++;
      if (tp == TN) begin
        n_cmp++;
        if (cyc - tfs_cyc != 2 * TH * TN) begin
          n_fail++;
          $display("FAIL tdm_frame_period cyc=%0d got=%0d want=%0d", cyc, cyc - tfs_cyc, 2 * TH * TN);
        end
        tp = 0;
        tfs_cyc = cyc;
      end
      t_act = {t_fs, t_slot, t_bit, t_lrclk};
      t_exp = {(tp == 0), 3'(tp / TSW), 5'(TSW - 1 - tp % TSW), (tp >= TN / 2)};
      n_cmp++;
      if (t_act !== t_exp) begin
        n_fail++;
        $display("FAIL tdm_position cyc=%0d got=%b want=%b", cyc, t_act, t_exp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int k;

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    bclk_half = 8'd2;
    i2s_mode  = 1'b0;
    t_rst_n   = 1'b0;
    t_en      = 1'b1;
    t_half    = 8'd1;
    t_mode    = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    t_rst_n = 1'b1;
    cycles(5);

    // defaults, left-justified
    enable = 1'b1;
    cycles(600);
    // rate change mid-frame, then half-period 0
    bclk_half = 8'd3;
    cycles(900);
    bclk_half = 8'd0;
    cycles(400);
    // I2S framing
    bclk_half = 8'd2;
    i2s_mode  = 1'b1;
    cycles(700);
    // short enable glitch inside a frame
    enable = 1'b0;
    cycles(10);
    enable = 1'b1;
    cycles(300);

    // randomized rate / mode / enable
    for (int i = 0; i < 12; i++) begin
      bclk_half = 8'($urandom_range(0, 4));
      i2s_mode  = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 3) != 0);
      cycles($urandom_range(50, 700));
    end

    // stop request at slot 0 bit 20
    bclk_half = 8'd2;
    i2s_mode  = 1'b0;
    enable    = 1'b1;
    cycles(1200);
    k = 0;
    while (!(active && slot_idx == '0 && bit_idx == BIW'(20)) && k < 2000) begin
      cycles(1);
      k++;
    end
    n_cmp++;
    if (k >= 2000) begin
      n_fail++;
      $display("FAIL wait_slot0_bit20 got=timeout want=reached");
    end
    enable = 1'b0;
    cycles(400);

    // restart, then asynchronous reset mid-frame
    enable = 1'b1;
    cycles(150);
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(600);

    enable = 1'b0;
    cycles(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
